// File: rtl/gesture_nn_pkg.sv
// Shared constants and types for the gesture network back end.
// The FC2 classifier sizes its datapath from these defaults.
package gesture_nn_pkg;

  localparam int DATA_W     = 8;
  localparam int FC1_N_OUT  = 128;
  localparam int N_GESTURES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_LOADB,
    S_MAC,
    S_CMP,
    S_DONE
  } cls_state_t;

  // A (2*data_w+1)-bit product summed n_in times, plus one bias, fits this signed width.
  function automatic int acc_width(input int data_w, input int n_in);
    return 2 * data_w + 1 + $clog2(n_in);
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of signed scores.
// The first score after clear always wins; later ones must be strictly greater, so ties keep the lower index.
module argmax_tracker #(
  parameter int IDX_W   = 3,
  parameter int SCORE_W = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      valid,
  input  logic [IDX_W-1:0]          idx,
  input  logic signed [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]          best_idx,
  output logic signed [SCORE_W-1:0] best_score
);

  logic have_best;
  logic take;

  assign take = valid && (!have_best || (score > best_score));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      have_best  <= 1'b0;
      best_idx   <= '0;
      best_score <= '0;
    end else if (take) begin
      have_best  <= 1'b1;
      best_idx   <= idx;
      best_score <= score;
    end
  end

endmodule

// File: rtl/fc2_argmax_classifier.sv
// FC2 layer plus argmax: bias + dot product per class over the FC1 activations,
// then reports the winning class and its logit with a done pulse.
module fc2_argmax_classifier #(
  parameter int DATA_W  = gesture_nn_pkg::DATA_W,
  parameter int N_IN    = gesture_nn_pkg::FC1_N_OUT,
  parameter int N_CLASS = gesture_nn_pkg::N_GESTURES,
  parameter int ACC_W   = gesture_nn_pkg::acc_width(DATA_W, N_IN)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(N_CLASS)-1:0]        class_id,
  output logic signed [ACC_W-1:0]           class_score,
  output logic [$clog2(N_IN)-1:0]           act_addr,
  input  logic [DATA_W-1:0]                 act_rdata,
  output logic [$clog2(N_IN*N_CLASS)-1:0]   w_addr,
  input  logic [DATA_W-1:0]                 w_rdata,
  output logic [$clog2(N_CLASS)-1:0]        b_addr,
  input  logic [DATA_W-1:0]                 b_rdata,
  output logic                              logit_valid,
  output logic [$clog2(N_CLASS)-1:0]        logit_idx,
  output logic signed [ACC_W-1:0]           logit_val
);

  import gesture_nn_pkg::*;

  localparam int CLS_W  = $clog2(N_CLASS);
  localparam int IDX_W  = $clog2(N_IN);
  localparam int WA_W   = $clog2(N_IN * N_CLASS);
  localparam int PROD_W = 2 * DATA_W + 1;

  cls_state_t state, state_next;

  logic [CLS_W-1:0]         cls;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         issue_idx;
  logic signed [ACC_W-1:0]  acc;
  logic [CLS_W-1:0]         class_id_q;
  logic signed [ACC_W-1:0]  class_score_q;
  logic [CLS_W-1:0]         best_idx;
  logic signed [ACC_W-1:0]  best_score;
  logic signed [PROD_W-1:0] act_s, w_s, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext;
  logic                     last_idx, last_cls;

  assign last_idx = (idx == IDX_W'(N_IN - 1));
  assign last_cls = (cls == CLS_W'(N_CLASS - 1));

  // Activation is unsigned post-ReLU, so it is zero-extended before the signed multiply.
  assign act_s    = {{(PROD_W - DATA_W){1'b0}}, act_rdata};
  assign w_s      = {{(PROD_W - DATA_W){w_rdata[DATA_W-1]}}, w_rdata};
  assign prod     = act_s * w_s;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W - DATA_W){b_rdata[DATA_W-1]}}, b_rdata};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: next-state starts from a default so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_BIAS;
      S_BIAS:  state_next = S_LOADB;
      S_LOADB: state_next = S_MAC;
      S_MAC:   if (last_idx) state_next = S_CMP;
      S_CMP:   state_next = last_cls ? S_DONE : S_BIAS;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cls           <= '0;
      idx           <= '0;
      acc           <= '0;
      class_id_q    <= '0;
      class_score_q <= '0;
    end else begin
      unique case (state)
        S_IDLE:  if (start) cls <= '0;
        S_BIAS:  ;
        S_LOADB: begin
          acc <= bias_ext;
          idx <= '0;
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + IDX_W'(1);
        end
        S_CMP:   if (!last_cls) cls <= cls + CLS_W'(1);
        S_DONE: begin
          class_id_q    <= best_idx;
          class_score_q <= best_score;
        end
        default: ;
      endcase
    end
  end

  // Read addresses come only from state/counters; data for index i arrives one cycle after issue.
  assign issue_idx = (state == S_MAC) ? idx + IDX_W'(1) : '0;
  assign act_addr  = issue_idx;
  assign w_addr    = WA_W'(cls) * WA_W'(N_IN) + WA_W'(issue_idx);
  assign b_addr    = cls;

  argmax_tracker #(
    .IDX_W   (CLS_W),
    .SCORE_W (ACC_W)
  ) u_argmax (
    .clk        (clk),
    .reset      (reset),
    .clear      ((state == S_IDLE) && start),
    .valid      (state == S_CMP),
    .idx        (cls),
    .score      (acc),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  // The tracker is final during DONE; the held copy takes over from the next cycle on.
  assign class_id    = done ? best_idx   : class_id_q;
  assign class_score = done ? best_score : class_score_q;
  assign logit_valid = (state == S_CMP);
  assign logit_idx   = cls;
  assign logit_val   = acc;

endmodule

// File: tb/tb_fc2_argmax_classifier.sv
// Self-checking bench for fc2_argmax_classifier: behavioural memories, a reference
// model feeding logit/result scoreboards, and directed plus random scenarios.
module tb_fc2_argmax_classifier;

  localparam int DW = 8;
  localparam int NI = 128;
  localparam int NC = 8;
  localparam int AW = 24;
  localparam int CW = $clog2(NC);
  localparam int IW = $clog2(NI);
  localparam int WW = $clog2(NI * NC);
  localparam int DONE_CYC = 1 + NC * (NI + 3);

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        class_id;
  logic signed [AW-1:0] class_score;
  logic [IW-1:0]        act_addr;
  logic [DW-1:0]        act_rdata;
  logic [WW-1:0]        w_addr;
  logic [DW-1:0]        w_rdata;
  logic [CW-1:0]        b_addr;
  logic [DW-1:0]        b_rdata;
  logic                 logit_valid;
  logic [CW-1:0]        logit_idx;
  logic signed [AW-1:0] logit_val;

  fc2_argmax_classifier #(
    .DATA_W  (DW),
    .N_IN    (NI),
    .N_CLASS (NC),
    .ACC_W   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .class_id    (class_id),
    .class_score (class_score),
    .act_addr    (act_addr),
    .act_rdata   (act_rdata),
    .w_addr      (w_addr),
    .w_rdata     (w_rdata),
    .b_addr      (b_addr),
    .b_rdata     (b_rdata),
    .logit_valid (logit_valid),
    .logit_idx   (logit_idx),
    .logit_val   (logit_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]        act_mem [NI];
  logic signed [DW-1:0] w_mem   [NI*NC];
  logic signed [DW-1:0] b_mem   [NC];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    w_rdata   <= w_mem[w_addr];
    b_rdata   <= b_mem[b_addr];
  end

  typedef struct {
    int     idx;
    longint val;
  } logit_t;

  typedef struct {
    int     id;
    longint score;
    longint ref_t;
    int     cyc;
  } res_t;

  logit_t logit_q[$];
  res_t   res_q[$];

  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;
  int     logit_extra = 0;
  int     last_id = 0;
  longint last_score = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: logits from current memory contents, argmax = first index holding the maximum.
  task automatic push_expect(input longint ref_t, input int cyc);
    longint lg [NC];
    longint mx;
    int     win;
    logit_t l;
    res_t   r;
    for (int c = 0; c < NC; c++) begin
      lg[c] = longint'(b_mem[c]);
      for (int i = 0; i < NI; i++)
        lg[c] += longint'(act_mem[i]) * longint'(w_mem[c*NI + i]);
      l.idx = c;
      l.val = lg[c];
      logit_q.push_back(l);
    end
    mx = lg[0];
    for (int c = 1; c < NC; c++) if (lg[c] > mx) mx = lg[c];
    win = -1;
    for (int c = NC - 1; c >= 0; c--) if (lg[c] == mx) win = c;
    r.id = win; r.score = mx; r.ref_t = ref_t; r.cyc = cyc;
    res_q.push_back(r);
    last_id = win;
    last_score = mx;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (logit_valid) begin
        if (logit_q.size() > 0) begin
          logit_t e;
          e = logit_q.pop_front();
          check("logit_idx", longint'(logit_idx), longint'(e.idx));
          check("logit_val", longint'(logit_val), e.val);
        end else begin
          logit_extra++;
        end
      end
      if (done) begin
        done_cnt++;
        if (res_q.size() > 0) begin
          res_t r;
          r = res_q.pop_front();
          check("class_id", longint'(class_id), longint'(r.id));
          check("class_score", longint'(class_score), r.score);
          check("done_cycle", ($time - r.ref_t - 5) / 10 + 1, longint'(r.cyc));
          check("busy_at_done", longint'(busy), 0);
        end
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, target);
    repeat (2) @(negedge clk);
    check("class_id_hold", longint'(class_id), longint'(last_id));
    check("class_score_hold", longint'(class_score), last_score);
  endtask

  // Returns the time of the accepting clock edge.
  task automatic launch(output longint t0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
  endtask

  task automatic run_one();
    longint t0;
    int     target;
    target = done_cnt + 1;
    launch(t0);
    push_expect(t0, DONE_CYC);
    @(negedge clk);
    start = 1'b0;
    wait_done(target, DONE_CYC + 100);
  endtask

  task automatic fill(input int act_v, input int w_v, input int b_v);
    for (int i = 0; i < NI; i++)      act_mem[i] = DW'(act_v);
    for (int i = 0; i < NI * NC; i++) w_mem[i]   = DW'(w_v);
    for (int c = 0; c < NC; c++)      b_mem[c]   = DW'(b_v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NI; i++)      act_mem[i] = DW'($urandom);
    for (int i = 0; i < NI * NC; i++) w_mem[i]   = DW'($urandom);
    for (int c = 0; c < NC; c++)      b_mem[c]   = DW'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    int     base;

    reset = 1'b1;
    start = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_class_id", longint'(class_id), 0);
    check("rst_class_score", longint'(class_score), 0);
    check("rst_logit_valid", longint'(logit_valid), 0);
    check("rst_logit_idx", longint'(logit_idx), 0);
    check("rst_logit_val", longint'(logit_val), 0);
    check("rst_act_addr", longint'(act_addr), 0);
    check("rst_w_addr", longint'(w_addr), 0);
    check("rst_b_addr", longint'(b_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    // Logits equal the biases 0..7.
    fill(0, 0, 0);
    for (int c = 0; c < NC; c++) b_mem[c] = DW'(c);
    run_one();

    // Only class 3 sees the activations.
    fill(1, 0, 0);
    for (int i = 0; i < NI; i++) w_mem[3*NI + i] = 8'sd1;
    run_one();

    // All logits tie at a negative value.
    fill(0, 0, -5);
    run_one();

    // Most negative product sum on class 5.
    fill(255, 0, 0);
    for (int i = 0; i < NI; i++) w_mem[5*NI + i] = -8'sd128;
    b_mem[5] = 8'sd127;
    run_one();

    // Extra start pulse mid-run must be ignored.
    fill_random();
    base = done_cnt;
    launch(t0);
    push_expect(t0, DONE_CYC);
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    start = 1'b1;
    check("busy_mid_run", longint'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 1, DONE_CYC);
    repeat (DONE_CYC + 50) @(negedge clk);
    check("single_done", done_cnt, base + 1);

    // Start held through DONE launches a back-to-back run.
    fill_random();
    for (int i = 0; i < NI * NC; i++) w_mem[i] = 8'sd0;
    for (int c = 0; c < NC; c++) b_mem[c] = 8'sd0;
    for (int i = 0; i < NI; i++) w_mem[6*NI + i] = 8'sd1;
    act_mem[0] = 8'd200;
    base = done_cnt;
    launch(t0);
    push_expect(t0, DONE_CYC);
    push_expect(t0, 2 * DONE_CYC + 1);
    repeat (DONE_CYC + 60) @(negedge clk);
    start = 1'b0;
    wait_done(base + 2, DONE_CYC + 100);
    repeat (DONE_CYC + 50) @(negedge clk);
    check("no_third_run", done_cnt, base + 2);

    // Reset in the middle of a run aborts it silently.
    fill_random();
    base = done_cnt;
    launch(t0);
    push_expect(t0, DONE_CYC);
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    logit_q.delete();
    res_q.delete();
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_done", longint'(done), 0);
    check("rst_mid_class_id", longint'(class_id), 0);
    check("rst_mid_class_score", longint'(class_score), 0);
    reset = 1'b0;
    repeat (DONE_CYC) @(negedge clk);
    check("rst_mid_no_done", done_cnt, base);
    check("rst_mid_idle", longint'(busy), 0);
    run_one();

    // Fully random contents.
    fill_random();
    run_one();
    fill_random();
    run_one();

    check("unexpected_logits", logit_extra, 0);
    check("scoreboard_drained", logit_q.size() + res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
